// File: rtl/mux_rr_arbiter.sv
// 4-client round-robin arbiter driving a 4:1 mux, burst-limited grants.
// MUX_RR_ARBITER_FIXED_PRIO_EN selects fixed A>B>C>D priority instead.
module mux_rr_arbiter #(
  parameter int WIDTH     = 2,
  parameter int MAX_BEATS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       REQ,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [3:0]       GNT,
  output logic [1:0]       SEL,
  output logic [WIDTH-1:0] X,
  output logic             VALID,
  output logic             BUSY
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [1:0]       last;
  logic [WIDTH-1:0] x;
  logic             valid;
  logic [BW-1:0]    beat;
  logic [1:0]       win;
  logic [WIDTH-1:0] dsel;

`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
  // Winner is the lowest set request bit.
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (REQ[i]) win = 2'(i);
  end
`else
  logic [1:0] idx;

  // Winner is the first request after the last winner, wrapping.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (REQ[idx]) win = idx;
    end
  end
`endif

  // Data of the currently granted client.
  always_comb begin
    case (sel)
      2'd0:    dsel = A;
      2'd1:    dsel = B;
      2'd2:    dsel = C;
      default: dsel = D;
    endcase
  end

  // Arbitration, beat transfer and release sequencing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      last  <= 2'd3;
      x     <= '0;
      valid <= 1'b0;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (|REQ) begin
            gnt   <= 4'b0001 << win;
            sel   <= win;
            last  <= win;
            beat  <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (REQ[sel]) begin
            x     <= dsel;
            valid <= 1'b1;
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              gnt   <= 4'b0000;
              state <= GAP;
            end else begin
              beat <= beat + 1'b1;
            end
          end else begin
            valid <= 1'b0;
            gnt   <= 4'b0000;
            state <= GAP;
          end
        end
        GAP: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          gnt   <= 4'b0000;
          state <= IDLE;
        end
      endcase
    end
  end

  assign GNT   = gnt;
  assign SEL   = sel;
  assign X     = x;
  assign VALID = valid;
  assign BUSY  = (state == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed literal checks plus random traffic
// compared every cycle against a grant/beat-level reference model.
module tb_mux_rr_arbiter;

  localparam int W  = 2;
  localparam int MB = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   REQ;
  logic [W-1:0] A, B, C, D;
  logic [3:0]   GNT;
  logic [1:0]   SEL;
  logic [W-1:0] X;
  logic         VALID, BUSY;

  int ncmp = 0;
  int nfail = 0;

  mux_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .A(A), .B(B), .C(C), .D(D),
    .GNT(GNT), .SEL(SEL), .X(X),
    .VALID(VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: who owns the mux, beats done, idle cycles owed.
  int           m_owner = -1;
  int           m_beats = 0;
  int           m_cool  = 0;
  int           m_last  = 3;
  int           m_sel   = 0;
  int           m_x     = 0;
  int           m_valid = 0;

  function automatic int pick(input logic [3:0] r, input int lst);
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++)
      if (r[k]) return k;
`else
    for (int k = 1; k <= 4; k++)
      if (r[(lst + k) % 4]) return (lst + k) % 4;
`endif
    return -1;
  endfunction

  function automatic int data_of(input int c);
    case (c)
      0:       return int'(A);
      1:       return int'(B);
      2:       return int'(C);
      default: return int'(D);
    endcase
  endfunction

  always @(posedge CLK or posedge RST) begin
    int w;
    if (RST) begin
      m_owner = -1; m_beats = 0; m_cool = 0;
      m_last = 3; m_sel = 0; m_x = 0; m_valid = 0;
    end else if (m_owner >= 0) begin
      if (REQ[m_owner]) begin
        m_x = data_of(m_owner);
        m_valid = 1;
        m_beats++;
        if (m_beats == MB) begin
          m_owner = -1;
          m_cool = 1;
        end
      end else begin
        m_valid = 0;
        m_owner = -1;
        m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
      m_valid = 0;
    end else begin
      m_valid = 0;
      w = pick(REQ, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last = w;
        m_sel = w;
        m_beats = 0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("m_gnt", int'(GNT), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("m_sel", int'(SEL), m_sel);
    chk("m_x", int'(X), m_x);
    chk("m_valid", int'(VALID), m_valid);
    chk("m_busy", int'(BUSY), (m_owner >= 0) ? 1 : 0);
  end

  initial begin
    int e;
    RST = 1'b1;
    REQ = 4'b1111;
    A = 2'd0; B = 2'd1; C = 2'd2; D = 2'd3;
    repeat (2) @(negedge CLK);
    chk("rst_gnt", int'(GNT), 0);
    chk("rst_sel", int'(SEL), 0);
    chk("rst_x", int'(X), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_busy", int'(BUSY), 0);
    RST = 1'b0;
    @(negedge CLK);
    for (int g = 0; g < 5; g++) begin
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
      e = 0;
`else
      e = g % 4;
`endif
      chk("rot_gnt", int'(GNT), 1 << e);
      chk("rot_sel", int'(SEL), e);
      for (int b = 0; b < MB; b++) begin
        @(negedge CLK);
        chk("rot_valid", int'(VALID), 1);
        chk("rot_x", int'(X), e);
      end
      chk("rot_rel", int'(GNT), 0);
      if (g == 4) REQ = 4'b0000;
      @(negedge CLK);
      chk("rot_gap", int'(GNT), 0);
      chk("rot_gapv", int'(VALID), 0);
      @(negedge CLK);
    end
    REQ = 4'b0100;
    @(negedge CLK);
    chk("c_gnt", int'(GNT), 4'b0100);
    chk("c_sel", int'(SEL), 2);
    for (int b = 0; b < MB; b++) begin
      @(negedge CLK);
      chk("c_valid", int'(VALID), 1);
      chk("c_x", int'(X), 2);
    end
    chk("c_rel", int'(GNT), 0);
    @(negedge CLK);
    chk("c_gap", int'(GNT), 0);
    @(negedge CLK);
    chk("c_regnt", int'(GNT), 4'b0100);
    REQ = 4'b0000;
    repeat (3) @(negedge CLK);
    REQ = 4'b0010;
    @(negedge CLK);
    chk("b_gnt", int'(GNT), 4'b0010);
    for (int b = 0; b < 2; b++) begin
      @(negedge CLK);
      chk("b_valid", int'(VALID), 1);
      chk("b_x", int'(X), 1);
    end
    REQ = 4'b0000;
    @(negedge CLK);
    chk("b_dropv", int'(VALID), 0);
    chk("b_busy", int'(BUSY), 0);
    chk("b_gnt0", int'(GNT), 0);
    repeat (2) @(negedge CLK);
    REQ = 4'b1000;
    @(negedge CLK);
    chk("d_gnt", int'(GNT), 4'b1000);
    repeat (2) @(negedge CLK);
    chk("d_valid", int'(VALID), 1);
    chk("d_x", int'(X), 3);
    #2 RST = 1'b1;
    #1;
    chk("ar_gnt", int'(GNT), 0);
    chk("ar_valid", int'(VALID), 0);
    chk("ar_busy", int'(BUSY), 0);
    chk("ar_sel", int'(SEL), 0);
    chk("ar_x", int'(X), 0);
    @(negedge CLK);
    REQ = 4'b1001;
    RST = 1'b0;
    @(negedge CLK);
    chk("ar_first", int'(GNT), 4'b0001);
    REQ = 4'b0000;
    repeat (8) @(negedge CLK);
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
    REQ = 4'b1011;
    @(negedge CLK);
    chk("fp_a1", int'(GNT), 4'b0001);
    repeat (MB + 2) @(negedge CLK);
    chk("fp_a2", int'(GNT), 4'b0001);
    chk("fp_sel", int'(SEL), 0);
    repeat (MB) @(negedge CLK);
    REQ = 4'b1010;
    repeat (2) @(negedge CLK);
    chk("fp_b", int'(GNT), 4'b0010);
    REQ = 4'b0000;
    repeat (8) @(negedge CLK);
`endif
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      A = W'($urandom);
      B = W'($urandom);
      C = W'($urandom);
      D = W'($urandom);
      if ($urandom_range(3) == 0) REQ = 4'($urandom);
      if ($urandom_range(199) == 0) begin
        #2 RST = 1'b1;
        #1 RST = 1'b0;
      end
    end
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

- Four-requester arbiter and sequencer for the 4:1 multiplexer datapath.
- Grants the shared mux to one requester at a time and drives SEL from the grant.
- Registers the selected data onto X for up to MAX_BEATS consecutive beats per grant.
- Sits between four client ports (A–D) and the single downstream consumer of X.

## Interface
- WIDTH, 2, data width of A, B, C, D and X.
- MAX_BEATS, 4, maximum beats per grant. Legal range 1–255.
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- REQ  input  4  request per client: bit0=A, bit1=B, bit2=C, bit3=D.
- A, B, C, D  input  WIDTH  client data.
- GNT  output  4  one-hot grant; 4'b0000 when no grant.
- SEL  output  2  mux select of the current/last grant (0=A … 3=D).
- X  output  WIDTH  registered selected data.
- VALID  output  1  X holds a beat transferred at the last edge.
- BUSY  output  1  high in the GRANT state.

## Operation
- **Reset values:** GNT=0, SEL=0, X=0, VALID=0, BUSY=0, state=IDLE, beat counter=0, round-robin pointer LAST=3 (A has first priority).
- **States:** IDLE, GRANT, GAP.
- **IDLE:**
  - At an edge with REQ!=0: pick winner w, the first set bit scanning from LAST+1 upward mod 4.
  - Set GNT=onehot(w), SEL=w, LAST=w, BEAT=0, state=GRANT.
  - Otherwise stay in IDLE.
- **GRANT, edge with REQ[w]=1:**
  - X<=data[w], VALID<=1, BEAT<=BEAT+1.
  - If BEAT==MAX_BEATS-1, this is the last beat: GNT<=0, state=GAP.
- **GRANT, edge with REQ[w]=0:** VALID<=0, GNT<=0, state=GAP. No transfer.
- **GAP:** VALID<=0, then IDLE at the next edge. REQ is ignored.
- **Non-granted REQ bits:** ignored while in GRANT or GAP. Requesters hold REQ until served. Dropping REQ before grant is allowed.
- **SEL, X outside GRANT:** both hold their last value. X is meaningful only when VALID=1.
- **Beat counter:** width is ceil(log2(MAX_BEATS+1)). It never exceeds MAX_BEATS-1 and clears on every new grant.
- **Forced release:** after MAX_BEATS beats, the grant is released even if REQ[w] stays high. The pointer rotation then serves other pending requesters first. A sole requester re-wins after GAP and IDLE.

## Timing
- REQ sampled in IDLE at edge e0 -> GNT/SEL/BUSY valid after e0.
- First beat on X with VALID=1 after e1.
- With continuous REQ, X carries beats after e1 … eMAX_BEATS. GNT falls after eMAX_BEATS.
- Gap between grants: GNT=0 for exactly 2 cycles (GAP, IDLE), so a new GNT appears after e(MAX_BEATS+2).
- MAX_BEATS=1: a single beat, then release.
- **Simultaneous events:**
  - Multiple REQ bits at one IDLE edge: a single winner per rotation rule.
  - REQ[w] falling on the same edge the last beat is due: no transfer, release.
- **RST asserted mid-grant:** all outputs and state go to their reset values immediately, with no clock required. The beat in flight is lost. After RST falls, arbitration resumes with A first.

## Configuration
- Macro: MUX_RR_ARBITER_FIXED_PRIO_EN.
- **Defined:**
  - Fixed priority A>B>C>D: the winner is the lowest set REQ bit.
  - LAST is not used for selection.
  - Forced release still applies, so a continuously requesting A starves the other clients.
- **Undefined (default):** round-robin behaviour as specified above.

## Test plan
- **Reset:** RST=1 with REQ=4'b1111 -> GNT=0, SEL=0, X=0, VALID=0, BUSY=0. RST falls -> first GNT=4'b0001.
- **Single requester:** A=2'b00, B=2'b01, C=2'b10, D=2'b11, REQ=4'b0100 held, MAX_BEATS=4.
  - GNT=4'b0100, SEL=2 after e0.
  - X=2'b10 with VALID=1 after e1–e4.
  - GNT=0 after e4.
  - GNT=4'b0100 again after e6.
- **Rotation:** REQ=4'b1111 held -> grant order A, B, C, D, A, with SEL=0,1,2,3,0. Each grant lasts 4 beats with a 2-cycle gap.
- **Early drop:** REQ=4'b0010, then drop REQ[1] after 2 beats -> exactly 2 VALID beats of X=2'b01, then GAP, then IDLE. BUSY=0 one edge after the drop.
- **Reset mid-grant:** assert RST asynchronously during beat 2 of a D grant -> outputs clear before the next CLK edge. After release, REQ=4'b1001 grants A first.
- **Fixed priority (MUX_RR_ARBITER_FIXED_PRIO_EN defined):** REQ=4'b1011 held -> A is regranted every time and SEL stays 0. Dropping REQ[0] -> B is granted next.
